// File: rtl/pipe_pkg.sv
// Shared pipeline types: forwarding select codes, datapath defaults and the
// registered EX-stage bookkeeping fields.
package pipe_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam logic [4:0]  REG_X0   = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_ALU2 = 2'b01,
        FWD_MEM3 = 2'b10,
        FWD_ALU3 = 2'b11
    } fwd_sel_e;

    // Per-instruction fields tracked in EX; a bubble is this struct all zero.
    typedef struct packed {
        logic       valid;
        logic       rf_we;
        logic       wb_sel;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ex_fields_t;

endpackage

// File: rtl/operand_bypass_mux.sv
// One EX operand: 4:1 forwarding select with an x0 guard that forces zero
// whenever the source register is x0.
module operand_bypass_mux
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [1:0]      sel,
    input  logic [4:0]      addr,
    input  logic [XLEN-1:0] rf_data,
    input  logic [XLEN-1:0] alu_result_2r,
    input  logic [XLEN-1:0] mem_rdata_3r,
    input  logic [XLEN-1:0] alu_result_3r,
    output logic [XLEN-1:0] op
);

    // Pick the operand source; x0 always reads as zero.
    always_comb begin
        op = '0;
        if (addr != REG_X0) begin
            case (fwd_sel_e'(sel))
                FWD_RF:   op = rf_data;
                FWD_ALU2: op = alu_result_2r;
                FWD_MEM3: op = mem_rdata_3r;
                FWD_ALU3: op = alu_result_3r;
            endcase
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble
// insertion. Optional feature macro: LOAD_USE_STALL_EN enables load-use
// detection; without it load-use is never flagged and the counter stays 0.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_rf_we,
    input  logic              id_wb_sel,
    input  logic [XLEN-1:0]   id_rf_data1,
    input  logic [XLEN-1:0]   id_rf_data2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              ex_stall,
    output logic [4:0]        rf_addr1,
    output logic [4:0]        rf_addr2,
    output logic [4:0]        ex_rd,
    output logic              ex_rf_we,
    output logic              ex_wb_sel,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_imm,
    output logic              ex_valid,
    input  logic [1:0]        rf_data1_sel,
    input  logic [1:0]        rf_data2_sel,
    input  logic [XLEN-1:0]   alu_result_2r,
    input  logic [XLEN-1:0]   alu_result_3r,
    input  logic [XLEN-1:0]   mem_rdata_3r,
    output logic [XLEN-1:0]   ex_op_a,
    output logic [XLEN-1:0]   ex_op_b,
    output logic [15:0]       hz_stall_cnt
);

    ex_fields_t        ex_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [XLEN-1:0]   imm_q;
    logic [XLEN-1:0]   data1_q;
    logic [XLEN-1:0]   data2_q;
    logic              load_use;
    logic              bubble;
    logic              load_id;

`ifdef LOAD_USE_STALL_EN
    assign load_use = ex_q.valid & ex_q.wb_sel & ex_q.rf_we & (ex_q.rd != REG_X0)
                    & id_valid & ((id_rs1 == ex_q.rd) | (id_rs2 == ex_q.rd));
`else
    assign load_use = 1'b0;
`endif

    // Flush outranks the downstream hold; load-use only acts when not held.
    assign bubble   = flush | (~ex_stall & load_use);
    assign load_id  = ~flush & ~ex_stall & ~load_use;
    assign id_ready = flush | (~ex_stall & ~load_use);

    // EX field register: bubble, hold, or capture from ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            ctrl_q  <= '0;
            imm_q   <= '0;
            data1_q <= '0;
            data2_q <= '0;
        end else if (bubble) begin
            ex_q   <= '0;
            ctrl_q <= '0;
        end else if (load_id) begin
            ex_q.valid  <= id_valid;
            ex_q.rf_we  <= id_rf_we;
            ex_q.wb_sel <= id_wb_sel;
            ex_q.rd     <= id_rd;
            ex_q.rs1    <= id_rs1;
            ex_q.rs2    <= id_rs2;
            ctrl_q      <= id_ctrl;
            imm_q       <= id_imm;
            data1_q     <= id_rf_data1;
            data2_q     <= id_rf_data2;
        end
    end

    // Count load-use bubbles only; a coincident flush claims the bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hz_stall_cnt <= '0;
        end else if (!flush && !ex_stall && load_use && (hz_stall_cnt != '1)) begin
            hz_stall_cnt <= hz_stall_cnt + 16'd1;
        end
    end

    assign rf_addr1  = ex_q.rs1;
    assign rf_addr2  = ex_q.rs2;
    assign ex_rd     = ex_q.rd;
    assign ex_rf_we  = ex_q.rf_we;
    assign ex_wb_sel = ex_q.wb_sel;
    assign ex_valid  = ex_q.valid;
    assign ex_ctrl   = ctrl_q;
    assign ex_imm    = imm_q;

    operand_bypass_mux #(.XLEN(XLEN)) u_mux_a (
        .sel           (rf_data1_sel),
        .addr          (ex_q.rs1),
        .rf_data       (data1_q),
        .alu_result_2r (alu_result_2r),
        .mem_rdata_3r  (mem_rdata_3r),
        .alu_result_3r (alu_result_3r),
        .op            (ex_op_a)
    );

    operand_bypass_mux #(.XLEN(XLEN)) u_mux_b (
        .sel           (rf_data2_sel),
        .addr          (ex_q.rs2),
        .rf_data       (data2_q),
        .alu_result_2r (alu_result_2r),
        .mem_rdata_3r  (mem_rdata_3r),
        .alu_result_3r (alu_result_3r),
        .op            (ex_op_b)
    );

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expectations track LOAD_USE_STALL_EN.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rf_we, id_wb_sel;
    logic [31:0] id_rf_data1, id_rf_data2, id_imm;
    logic [7:0]  id_ctrl;
    logic        flush, ex_stall;
    logic [4:0]  rf_addr1, rf_addr2, ex_rd;
    logic        ex_rf_we, ex_wb_sel, ex_valid;
    logic [7:0]  ex_ctrl;
    logic [31:0] ex_imm;
    logic [1:0]  rf_data1_sel, rf_data2_sel;
    logic [31:0] alu_result_2r, alu_result_3r, mem_rdata_3r;
    logic [31:0] ex_op_a, ex_op_b;
    logic [15:0] hz_stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .CTRL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rf_we(id_rf_we),
        .id_wb_sel(id_wb_sel), .id_rf_data1(id_rf_data1), .id_rf_data2(id_rf_data2),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .flush(flush), .ex_stall(ex_stall),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .ex_rd(ex_rd), .ex_rf_we(ex_rf_we),
        .ex_wb_sel(ex_wb_sel), .ex_ctrl(ex_ctrl), .ex_imm(ex_imm), .ex_valid(ex_valid),
        .rf_data1_sel(rf_data1_sel), .rf_data2_sel(rf_data2_sel),
        .alu_result_2r(alu_result_2r), .alu_result_3r(alu_result_3r),
        .mem_rdata_3r(mem_rdata_3r), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .hz_stall_cnt(hz_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic we, input logic wb,
                          input logic [31:0] d1, input logic [31:0] d2);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_rf_we    = we;
        id_wb_sel   = wb;
        id_rf_data1 = d1;
        id_rf_data2 = d2;
    endtask

    initial begin
        rst_n = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        id_imm = '0; id_ctrl = '0; flush = 1'b0; ex_stall = 1'b0;
        rf_data1_sel = 2'b00; rf_data2_sel = 2'b00;
        alu_result_2r = '0; alu_result_3r = '0; mem_rdata_3r = '0;
        tick(); tick();

        // Reset state
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
        chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
        chk("rst_cnt", {16'd0, hz_stall_cnt}, 32'd0);
        chk("rst_op_a", ex_op_a, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // add x3,x1,x2
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'd5, 32'd7);
        id_imm = 32'h10; id_ctrl = 8'h5A;
        #1 chk("add_id_ready", {31'd0, id_ready}, 32'd1);
        tick();
        chk("add_op_a", ex_op_a, 32'd5);
        chk("add_op_b", ex_op_b, 32'd7);
        chk("add_ex_rd", {27'd0, ex_rd}, 32'd3);
        chk("add_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("add_rf_addr1", {27'd0, rf_addr1}, 32'd1);
        chk("add_ex_ctrl", {24'd0, ex_ctrl}, 32'h5A);
        chk("add_ex_imm", ex_imm, 32'h10);
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Bypass selects on the held add (stall keeps it in EX)
        ex_stall = 1'b1;
        rf_data1_sel = 2'b01; alu_result_2r = 32'h1234;
        #1 chk("byp_alu2", ex_op_a, 32'h1234);
        rf_data1_sel = 2'b10; mem_rdata_3r = 32'hAA;
        #1 chk("byp_mem3", ex_op_a, 32'hAA);
        rf_data1_sel = 2'b11; alu_result_3r = 32'hBB;
        #1 chk("byp_alu3", ex_op_a, 32'hBB);
        rf_data2_sel = 2'b01;
        #1 chk("byp_b_alu2", ex_op_b, 32'h1234);
        rf_data1_sel = 2'b00; rf_data2_sel = 2'b00;
        ex_stall = 1'b0;

        // x0 guard
        set_id(1'b1, 5'd0, 5'd2, 5'd4, 1'b1, 1'b0, 32'd9, 32'd3);
        tick();
        rf_data1_sel = 2'b01; alu_result_2r = 32'hFFFF;
        #1 chk("x0_op_a", ex_op_a, 32'd0);
        chk("x0_op_b", ex_op_b, 32'd3);
        rf_data1_sel = 2'b00;

        // lw x5 then dependent add x6,x5,x1
        set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 32'd1, 32'd0);
        @(negedge clk);
        tick();
        chk("lw_ex_rd", {27'd0, ex_rd}, 32'd5);
        chk("lw_ex_wb_sel", {31'd0, ex_wb_sel}, 32'd1);
        set_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 32'h55, 32'h66);
        #1;
`ifdef LOAD_USE_STALL_EN
        chk("lu_id_ready", {31'd0, id_ready}, 32'd0);
        tick();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_rd", {27'd0, ex_rd}, 32'd0);
        chk("lu_bubble_addr1", {27'd0, rf_addr1}, 32'd0);
        chk("lu_cnt", {16'd0, hz_stall_cnt}, 32'd1);
        chk("lu_id_ready_after", {31'd0, id_ready}, 32'd1);
        tick();
`else
        chk("nolu_id_ready", {31'd0, id_ready}, 32'd1);
        tick();
`endif
        rf_data1_sel = 2'b10; mem_rdata_3r = 32'hAA;
        #1 chk("lu_add_rd", {27'd0, ex_rd}, 32'd6);
        chk("lu_add_addr1", {27'd0, rf_addr1}, 32'd5);
        chk("lu_add_op_a", ex_op_a, 32'hAA);
        rf_data1_sel = 2'b00;

        // flush + load-use + ex_stall
        set_id(1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1, 32'd0, 32'd0);
        tick();
        set_id(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0, 32'd0, 32'd0);
        flush = 1'b1; ex_stall = 1'b1;
        #1 chk("fl_id_ready", {31'd0, id_ready}, 32'd1);
        tick();
        chk("fl_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("fl_ex_rd", {27'd0, ex_rd}, 32'd0);
        chk("fl_ex_ctrl", {24'd0, ex_ctrl}, 32'd0);
`ifdef LOAD_USE_STALL_EN
        chk("fl_cnt", {16'd0, hz_stall_cnt}, 32'd1);
`else
        chk("fl_cnt", {16'd0, hz_stall_cnt}, 32'd0);
`endif
        flush = 1'b0; ex_stall = 1'b0;

        // ex_stall hold
        set_id(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 32'd1, 32'd2);
        tick();
        set_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 32'd1, 32'd2);
        ex_stall = 1'b1;
        #1 chk("st_id_ready", {31'd0, id_ready}, 32'd0);
        tick();
        chk("st_hold_rd", {27'd0, ex_rd}, 32'd8);
        ex_stall = 1'b0;
        tick();
        chk("st_release_rd", {27'd0, ex_rd}, 32'd9);

        // Reset asserted mid-stall
        ex_stall = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1 chk("mr_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("mr_ex_rd", {27'd0, ex_rd}, 32'd0);
        ex_stall = 1'b0;
        #1 chk("mr_id_ready", {31'd0, id_ready}, 32'd1);
        chk("mr_cnt", {16'd0, hz_stall_cnt}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        set_id(1'b1, 5'd3, 5'd4, 5'd10, 1'b1, 1'b0, 32'd0, 32'd0);
        tick();
        chk("mr_accept_rd", {27'd0, ex_rd}, 32'd10);
        chk("mr_accept_valid", {31'd0, ex_valid}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the five-stage core. It captures the decoded instruction from ID and presents its source-register addresses to the forwarding unit. It applies the forwarding unit's select codes to build the EX operands, and detects load-use hazards, stalling ID and inserting a bubble. It sits between the decoder/register file and the ALU, and is the sole consumer of `rf_data1_sel`/`rf_data2_sel`.

## Interface
- `XLEN`, 32, datapath width
- `CTRL_W`, 8, width of the opaque EX/MEM control bundle (ALU op, branch, mem size)
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `id_valid`  in  1  ID holds a valid instruction
- `id_ready`  out  1  ID/EX accepts this cycle; deasserted = ID and IF hold
- `id_rs1`, `id_rs2`  in  5  source register addresses
- `id_rd`  in  5  destination register
- `id_rf_we`  in  1  instruction writes rd
- `id_wb_sel`  in  1  1 = load (write-back from memory), 0 = ALU
- `id_rf_data1`, `id_rf_data2`  in  XLEN  register-file read data
- `id_imm`  in  XLEN  immediate
- `id_ctrl`  in  CTRL_W  control bundle
- `flush`  in  1  branch/jump redirect, kill the instruction entering EX
- `ex_stall`  in  1  downstream hold (memory busy)
- `rf_addr1`, `rf_addr2`  out  5  registered rs1/rs2, to forwarding
- `ex_rd`, `ex_rf_we`, `ex_wb_sel`, `ex_ctrl`, `ex_imm`, `ex_valid`  out  various  registered EX fields
- `rf_data1_sel`, `rf_data2_sel`  in  2  select codes from forwarding
- `alu_result_2r`  in  XLEN  EX/MEM ALU result
- `alu_result_3r`, `mem_rdata_3r`  in  XLEN  MEM/WB ALU result and load data
- `ex_op_a`, `ex_op_b`  out  XLEN  forwarded operands
- `hz_stall_cnt`  out  16  saturating count of load-use bubbles

## Operation
- Select decode: 00 = registered RF data, 01 = `alu_result_2r`, 10 = `mem_rdata_3r`, 11 = `alu_result_3r`.
- If `rf_addr1` is 0, `ex_op_a` is forced to 0 regardless of the select code. `rf_addr2`/`ex_op_b` behave the same way.
- Load-use condition: `ex_valid & ex_wb_sel & ex_rf_we & ex_rd!=0 & id_valid & (id_rs1==ex_rd | id_rs2==ex_rd)`.
- Register update priority, evaluated each rising edge:
  - `flush`: load a bubble.
  - else `ex_stall`: hold all registers.
  - else load-use: load a bubble. ID is held by `id_ready`=0.
  - else: load the ID fields, with `ex_valid`=`id_valid`.
- Bubble: `ex_valid`=0, `ex_rf_we`=0, `ex_rd`=0, `rf_addr1`/`rf_addr2`=0, `ex_ctrl`=0. The zeroed addresses guarantee the forwarding unit never matches on a bubble.
- `id_ready` = `flush | (!ex_stall & !load_use)`.
- `hz_stall_cnt` increments on each bubble inserted by a load-use, saturating at 0xFFFF. Flush bubbles and `ex_stall` holds do not count.

## Timing
- Reset (async assert, sync release): all registered outputs 0 and `hz_stall_cnt`=0. The derived outputs follow: `ex_op_a`/`ex_op_b`=0 and `id_ready`=1.
- Latency: ID fields appear on the EX outputs 1 cycle after acceptance.
- `ex_op_a`/`ex_op_b` are combinational from registered data, select codes and bypass inputs, with no added cycle.
- A load-use costs exactly one bubble. On the next cycle the load sits in EX/MEM with `wb_sel`=1; the consumer then enters EX and receives select 10 from MEM/WB.
- `flush` together with load-use: the bubble counts as a flush and the counter does not increment.
- `flush` together with `ex_stall`: flush wins.
- Reset asserted mid-stall clears the state immediately. The first cycle after release accepts ID.

## Configuration
- `LOAD_USE_STALL_EN` defined: load-use detection as above.
- Not defined: load-use is tied to 0, so `id_ready` = `flush | !ex_stall`, and `hz_stall_cnt` stays 0. Software scheduling must then place a non-dependent instruction after each load.

## Structure
- Package `pipe_pkg` holds:
  - `fwd_sel_e` (FWD_RF=2'b00, FWD_ALU2=2'b01, FWD_MEM3=2'b10, FWD_ALU3=2'b11)
  - the `XLEN` default and the `REG_X0` constant
  - the EX-stage field struct
- Sub-module `operand_bypass_mux` (4:1 mux plus x0 guard) is instantiated twice, once per operand.

## Test plan
- Reset with `rst_n`=0 mid-traffic -> all registered outputs 0, `id_ready`=1, counter 0.
- Independent `add x3,x1,x2` with `id_rf_data1`=5, `id_rf_data2`=7, selects 00 -> next cycle `ex_op_a`=5, `ex_op_b`=7, `ex_rd`=3.
- Bypass: drive select 01 with `alu_result_2r`=0x1234 -> `ex_op_a`=0x1234. Repeat with 10/`mem_rdata_3r`=0xAA and 11/`alu_result_3r`=0xBB.
- `lw x5` in EX, `add x6,x5,x1` in ID -> `id_ready`=0 for one cycle, bubble with `ex_rd`=0, counter=1. Next cycle the add enters EX. Without the macro: no stall and counter stays 0.
- `flush` with load-use and `ex_stall` all high -> bubble loaded, `id_ready`=1, counter unchanged.
- `rf_addr1`=0 with select 01 and `alu_result_2r`=0xFFFF -> `ex_op_a`=0.
